// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage between a synchronous instruction memory (one cycle
// read latency) and the decoder. Owns the program counter, issues one read at
// a time, captures the returned word and presents it to the decoder under a
// valid/ready handshake. Jumps and halts take effect only at an instruction
// boundary, i.e. in the cycle the decoder accepts the held instruction.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   start           begin fetching from the current pc (only from IDLE)
//   halt            stop after the instruction in flight has been delivered
//   PC_address,rEn  address / read enable to the instruction memory
//   ins_mem_data    memory read data, valid the cycle after rEn
//   ins_out,pc_out  held instruction and the address it came from
//   ins_valid       ins_out/pc_out valid; accepted when ins_ready is high
//   jump_en         redirect pc to jump_addr at the accepting handshake
//   busy            high in every state other than IDLE
// ---------------------------------------------------------------------------
module fetch_unit #(
   parameter int                    ADDR_WIDTH = 8,
   parameter int                    INS_WIDTH  = 9,
   parameter logic [ADDR_WIDTH-1:0] START_ADDR = {ADDR_WIDTH{1'b0}}
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  halt,
   output logic [ADDR_WIDTH-1:0] PC_address,
   output logic                  rEn,
   input  logic [INS_WIDTH-1:0]  ins_mem_data,
   output logic [INS_WIDTH-1:0]  ins_out,
   output logic [ADDR_WIDTH-1:0] pc_out,
   output logic                  ins_valid,
   input  logic                  ins_ready,
   input  logic                  jump_en,
   input  logic [ADDR_WIDTH-1:0] jump_addr,
   output logic                  busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_FETCH = 2'b01,
      ST_WAIT  = 2'b10,
      ST_HOLD  = 2'b11
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] PC_STEP = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   state_t                  state_r;
   logic [ADDR_WIDTH-1:0]   pc_r;
   logic                    halt_pending_r;
   logic                    handshake_s;

   // The memory address is the pc register itself, so it is glitch-free.
   assign PC_address  = pc_r;
   assign handshake_s = ins_valid & ins_ready;

   // Fetch sequencer: state, pc, halt latch and all registered outputs.
   // rEn and busy are computed from the next state so they line up exactly
   // with the state they describe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r        <= ST_IDLE;
         pc_r           <= START_ADDR;
         halt_pending_r <= 1'b0;
         ins_out        <= {INS_WIDTH{1'b0}};
         pc_out         <= {ADDR_WIDTH{1'b0}};
         ins_valid      <= 1'b0;
         rEn            <= 1'b0;
         busy           <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               // halt is neither acted on nor remembered while idle.
               if (start) begin
                  state_r <= ST_FETCH;
                  rEn     <= 1'b1;
                  busy    <= 1'b1;
               end else begin
                  rEn     <= 1'b0;
                  busy    <= 1'b0;
               end
            end
            ST_FETCH: begin
               // Memory registers mem[pc] on this edge.
               if (halt) begin
                  halt_pending_r <= 1'b1;
               end
               state_r <= ST_WAIT;
               rEn     <= 1'b0;
            end
            ST_WAIT: begin
               if (halt) begin
                  halt_pending_r <= 1'b1;
               end
               ins_out   <= ins_mem_data;
               pc_out    <= pc_r;
               ins_valid <= 1'b1;
               pc_r      <= pc_r + PC_STEP;
               state_r   <= ST_HOLD;
            end
            ST_HOLD: begin
               if (handshake_s) begin
                  ins_valid <= 1'b0;
                  // A jump replaces the already incremented pc.
                  if (jump_en) begin
                     pc_r <= jump_addr;
                  end
                  if (halt_pending_r || halt) begin
                     state_r        <= ST_IDLE;
                     halt_pending_r <= 1'b0;
                     rEn            <= 1'b0;
                     busy           <= 1'b0;
                  end else begin
                     state_r <= ST_FETCH;
                     rEn     <= 1'b1;
                  end
               end else if (halt) begin
                  halt_pending_r <= 1'b1;
               end
            end
            default: begin
               state_r        <= ST_IDLE;
               halt_pending_r <= 1'b0;
               ins_valid      <= 1'b0;
               rEn            <= 1'b0;
               busy           <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Directed scenarios (reset, streaming, backpressure, jump, halt, wrap,
// start+halt in IDLE) followed by a randomized run checked against a
// transaction-level model: each accepted instruction must be mem[pc] from the
// expected pc, and the next expected pc is jump_addr or pc+1.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

   localparam int AW = 8;
   localparam int IW = 9;

   logic          clk = 1'b0;
   logic          rst;
   logic          start, halt, ins_ready, jump_en;
   logic [AW-1:0] jump_addr;
   logic [AW-1:0] PC_address, pc_out;
   logic          rEn, ins_valid, busy;
   logic [IW-1:0] ins_mem_data = 9'h000;
   logic [IW-1:0] ins_out;

   logic [IW-1:0] mem [256];

   int passed = 0;
   int total  = 0;
   int failed = 0;

   // model state for the randomized run
   logic [AW-1:0] exp_pc;
   logic          running;
   logic          stop_req;
   logic          hs;

   always #5 clk = ~clk;

   fetch_unit #(.ADDR_WIDTH(AW), .INS_WIDTH(IW), .START_ADDR(8'h00)) dut (
      .clk(clk), .rst(rst), .start(start), .halt(halt),
      .PC_address(PC_address), .rEn(rEn), .ins_mem_data(ins_mem_data),
      .ins_out(ins_out), .pc_out(pc_out), .ins_valid(ins_valid),
      .ins_ready(ins_ready), .jump_en(jump_en), .jump_addr(jump_addr),
      .busy(busy)
   );

   // instruction memory: one cycle read latency
   always @(posedge clk) begin
      if (rEn) ins_mem_data <= mem[PC_address];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk9(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; halt = 1'b0; ins_ready = 1'b0;
      jump_en = 1'b0; jump_addr = 8'h00;
      for (int i = 0; i < 256; i++) mem[i] = 9'($urandom);
      mem[0] = 9'h101; mem[1] = 9'h0A2; mem[2] = 9'h1FF;

      // ---- reset state
      #1 rst = 1'b1;
      #2;
      chk1("rst_valid", ins_valid, 1'b0);
      chk1("rst_ren", rEn, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk8("rst_pc_addr", PC_address, 8'h00);
      chk8("rst_pc_out", pc_out, 8'h00);
      chk9("rst_ins_out", ins_out, 9'h000);
      tick();
      rst = 1'b0;
      tick();

      // ---- streaming with ins_ready tied high, halt on the third
      ins_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int n = 0; n < 3; n++) begin
         chk1("str_fetch_ren", rEn, 1'b1);
         chk8("str_fetch_addr", PC_address, 8'(n));
         chk1("str_fetch_valid", ins_valid, 1'b0);
         chk1("str_busy", busy, 1'b1);
         tick();
         chk1("str_wait_ren", rEn, 1'b0);
         chk1("str_wait_valid", ins_valid, 1'b0);
         tick();
         chk1("str_hold_valid", ins_valid, 1'b1);
         chk9("str_ins_out", ins_out, mem[n]);
         chk8("str_pc_out", pc_out, 8'(n));
         chk1("str_hold_ren", rEn, 1'b0);
         if (n == 2) halt = 1'b1;
         tick();
         halt = 1'b0;
      end
      chk1("str_idle_busy", busy, 1'b0);
      chk1("str_idle_ren", rEn, 1'b0);
      chk1("str_idle_valid", ins_valid, 1'b0);
      tick();
      chk1("str_idle_stays", busy, 1'b0);

      // ---- halt during WAIT of pc 3, then restart at 4
      start = 1'b1;
      tick();
      start = 1'b0;
      chk8("hlt_fetch_addr", PC_address, 8'h03);
      tick();
      halt = 1'b1;
      tick();
      halt = 1'b0;
      chk1("hlt_delivered_valid", ins_valid, 1'b1);
      chk8("hlt_delivered_pc", pc_out, 8'h03);
      chk9("hlt_delivered_ins", ins_out, mem[3]);
      tick();
      chk1("hlt_idle_busy", busy, 1'b0);
      chk1("hlt_idle_ren", rEn, 1'b0);
      tick();
      tick();
      chk1("hlt_idle_holds", busy, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk8("hlt_restart_addr", PC_address, 8'h04);
      chk1("hlt_restart_ren", rEn, 1'b1);
      tick();
      tick();
      chk8("hlt_pc4_out", pc_out, 8'h04);
      tick();
      tick();
      ins_ready = 1'b0;
      tick();
      chk8("rsth_pc_out_pre", pc_out, 8'h05);
      chk1("rsth_valid_pre", ins_valid, 1'b1);

      // ---- asynchronous reset in the middle of HOLD
      #2 rst = 1'b1;
      #1;
      chk1("rsth_valid", ins_valid, 1'b0);
      chk9("rsth_ins_out", ins_out, 9'h000);
      chk8("rsth_pc_out", pc_out, 8'h00);
      chk1("rsth_ren", rEn, 1'b0);
      chk1("rsth_busy", busy, 1'b0);
      tick();
      rst = 1'b0;
      chk8("rsth_pc_addr", PC_address, 8'h00);

      // ---- backpressure in HOLD of pc 1, ignored jumps
      ins_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick(); tick();
      ins_ready = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         chk9("bp_ins_out", ins_out, 9'h0A2);
         chk8("bp_pc_out", pc_out, 8'h01);
         chk1("bp_valid", ins_valid, 1'b1);
         chk1("bp_ren", rEn, 1'b0);
         jump_en = (i == 2);
         jump_addr = 8'h80;
         tick();
      end
      jump_en = 1'b0;
      chk1("bp_valid_end", ins_valid, 1'b1);
      ins_ready = 1'b1;
      tick();
      chk1("bp_next_ren", rEn, 1'b1);
      chk8("bp_next_addr", PC_address, 8'h02);
      tick();
      jump_en = 1'b1;
      jump_addr = 8'h33;
      tick();
      jump_en = 1'b0;
      chk8("bp_pc2_out", pc_out, 8'h02);
      halt = 1'b1;
      tick();
      halt = 1'b0;
      chk1("bp_idle", busy, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk8("wait_jump_ignored", PC_address, 8'h03);
      rst = 1'b1;
      tick();
      rst = 1'b0;

      // ---- jump at handshake of pc 1, wrap-around at 0xFF
      ins_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick(); tick(); tick();
      chk8("jmp_pc_out", pc_out, 8'h01);
      jump_en = 1'b1;
      jump_addr = 8'h40;
      tick();
      jump_en = 1'b0;
      chk8("jmp_target", PC_address, 8'h40);
      chk1("jmp_ren", rEn, 1'b1);
      tick(); tick();
      chk8("jmp_pc_out40", pc_out, 8'h40);
      chk9("jmp_ins_out40", ins_out, mem[8'h40]);
      ins_ready = 1'b0;
      jump_en = 1'b1;
      jump_addr = 8'h20;
      tick();
      jump_en = 1'b0;
      chk1("jmp_bp_valid", ins_valid, 1'b1);
      ins_ready = 1'b1;
      tick();
      chk8("jmp_bp_ignored", PC_address, 8'h41);
      tick(); tick();
      jump_en = 1'b1;
      jump_addr = 8'hFF;
      tick();
      jump_en = 1'b0;
      chk8("wrap_fetch_ff", PC_address, 8'hFF);
      tick(); tick();
      chk8("wrap_pc_out", pc_out, 8'hFF);
      chk9("wrap_ins_out", ins_out, mem[8'hFF]);
      tick();
      chk8("wrap_next_addr", PC_address, 8'h00);
      tick();
      halt = 1'b1;
      tick();
      halt = 1'b0;
      tick();
      chk1("wrap_idle", busy, 1'b0);

      // ---- start and halt together in IDLE: start wins, halt not latched
      start = 1'b1;
      halt = 1'b1;
      tick();
      start = 1'b0;
      halt = 1'b0;
      chk1("sh_ren", rEn, 1'b1);
      chk8("sh_addr", PC_address, 8'h01);
      tick(); tick(); tick();
      chk1("sh_continues_busy", busy, 1'b1);
      chk1("sh_continues_ren", rEn, 1'b1);
      chk8("sh_continues_addr", PC_address, 8'h02);

      // ---- randomized run against the transaction model
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_pc = 8'h00;
      running = 1'b0;
      stop_req = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         start     = ($urandom_range(0, 3) == 32'd0);
         halt      = ($urandom_range(0, 15) == 32'd0);
         ins_ready = ($urandom_range(0, 2) != 32'd0);
         jump_en   = ($urandom_range(0, 3) == 32'd0);
         jump_addr = 8'($urandom);
         chk1("rnd_busy", busy, running);
         if (rEn) chk8("rnd_fetch_addr", PC_address, exp_pc);
         hs = ins_valid && ins_ready;
         if (hs) begin
            chk9("rnd_ins_out", ins_out, mem[exp_pc]);
            chk8("rnd_pc_out", pc_out, exp_pc);
         end
         if (!running) begin
            if (start) running = 1'b1;
         end else if (hs) begin
            exp_pc = jump_en ? jump_addr : exp_pc + 8'd1;
            if (stop_req || halt) begin
               running  = 1'b0;
               stop_req = 1'b0;
            end
         end else if (halt) begin
            stop_req = 1'b1;
         end
         tick();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage. Sits directly upstream of the 9-bit synchronous instruction memory and downstream-facing to the decoder.
- Owns the program counter and drives the memory's address and read-enable.
- Captures each returned word after the memory's 1-cycle read latency and holds it for the decoder under a valid/ready handshake.
- Applies jumps and halts at instruction boundaries.

Parameters:
- ADDR_WIDTH, 8, PC / memory address width.
- INS_WIDTH, 9, instruction word width.
- START_ADDR, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin fetching from current PC; honoured only in IDLE.
- halt  in  1  request stop at the next instruction boundary; pulse, latched internally.
- PC_address  out  ADDR_WIDTH  address to instruction memory.
- rEn  out  1  read enable to instruction memory.
- ins_mem_data  in  INS_WIDTH  memory read data, valid the cycle after rEn=1.
- ins_out  out  INS_WIDTH  held instruction for the decoder.
- pc_out  out  ADDR_WIDTH  address that ins_out was fetched from.
- ins_valid  out  1  ins_out/pc_out are valid.
- ins_ready  in  1  decoder accepts ins_out this cycle.
- jump_en  in  1  redirect the PC; qualified by handshake.
- jump_addr  in  ADDR_WIDTH  jump target.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (async, immediate, mid-operation included):
  - state=IDLE, pc=START_ADDR, halt_pending=0.
  - ins_out=0, pc_out=0, ins_valid=0.
  - rEn=0, PC_address=START_ADDR.
  - Any in-flight fetch is discarded.
- Registered outputs: PC_address always equals the pc register. rEn=1 exactly in state FETCH (decoded from state, glitch-free). busy=(state!=IDLE).
- IDLE: rEn=0. If start=1, go to FETCH. halt is ignored and not latched in IDLE, so start wins if both are asserted.
- FETCH (1 cycle): rEn=1, PC_address=pc; memory registers mem[pc] on this edge. Always go to WAIT.
- WAIT (1 cycle): rEn=0. On the edge ending WAIT:
  - ins_out<=ins_mem_data, pc_out<=pc, ins_valid<=1.
  - pc<=pc+1, modulo 2**ADDR_WIDTH (e.g. 8'hFF wraps to 8'h00).
  - Go to HOLD.
- HOLD:
  - ins_valid=1. ins_out and pc_out are stable until the handshake.
  - Handshake = ins_valid & ins_ready.
  - On handshake: ins_valid<=0. If jump_en=1, pc<=jump_addr, overriding the incremented pc. Next state is IDLE if halt_pending or halt is high this cycle, else FETCH. halt_pending clears on entering IDLE.
  - Without handshake: remain in HOLD and hold all outputs. jump_en is ignored.
- jump_en is honoured only in a HOLD handshake cycle and is ignored in every other cycle or state.
- halt_pending: set by halt=1 in FETCH, WAIT or HOLD. Cleared only on the HOLD->IDLE transition or by reset. The instruction already in flight is always delivered before stopping.
- Restart after halt resumes from the retained pc; pc is not reset.
- Throughput: 3 cycles per instruction when ins_ready is held high (FETCH, WAIT, HOLD).
- Latency: start-high edge to ins_valid=1 is 3 rising edges: IDLE->FETCH, FETCH->WAIT, WAIT->HOLD.
- Only one memory read is outstanding at a time; no prefetch.
- ins_mem_data is sampled only on the WAIT edge.

Test Plan:
- Reset mid-HOLD (pc_out=0x05, ins_valid=1), assert rst between edges -> ins_valid, ins_out, pc_out and rEn go to 0 immediately, without waiting for a clock edge. PC_address=0x00 after rst deasserts.
- Memory mem[0..2]=0x101,0x0A2,0x1FF; start pulse, ins_ready tied 1 -> ins_out sequence 0x101,0x0A2,0x1FF with pc_out 0,1,2. ins_valid is high 1 cycle in every 3. rEn is high in exactly the FETCH cycles with PC_address 0,1,2.
- Backpressure: ins_ready=0 for 5 cycles in HOLD with ins_out=0x0A2 -> ins_out, pc_out and ins_valid are held stable and rEn stays 0. After ins_ready=1, the next fetch uses PC_address=0x02.
- Jump: at handshake of pc_out=0x01, drive jump_en=1 with jump_addr=0x40 -> the next FETCH has PC_address=0x40. A jump_en pulse in WAIT, or in HOLD with ins_ready=0, has no effect.
- Halt: pulse halt during WAIT of pc=0x03 -> instruction 0x03 is still delivered, then IDLE with busy=0 and rEn=0. A later start pulse fetches 0x04.
- Wrap-around: jump to 0xFF -> fetch 0xFF, then the next FETCH has PC_address=0x00. start and halt asserted together in IDLE -> fetching begins and halt is not latched.
